// File: rtl/nf10_upb_input_arbiter.sv
// -----------------------------------------------------------------------------
// nf10_upb_input_arbiter
//
// Merges NUM_PORTS AXI-Stream source ports (10G MACs + DMA) onto the single
// input stream of nf10_upb_switch. Arbitration is round-robin at packet
// granularity: once a port is granted, it keeps the grant until its tlast
// beat is accepted, so packets are never interleaved.
//
// The merged stream is stamped with the granted port index in
// m_axis_tuser_in_port. out_port/out_vport are driven to zero because the
// downstream lookup fills them in.
//
// Ports
//   clk, resetn                  core clock, asynchronous active-low reset
//   s_axis_*  (NUM_PORTS wide)   per-port source streams; port i's tdata
//                                lives at [i*DATA_W +: DATA_W], tkeep at
//                                [i*DATA_W/8 +: DATA_W/8], in_vport at
//                                [i*3 +: 3], packet_length at [i*14 +: 14]
//   s_axis_tready                per-port ready, only the granted port sees it
//   m_axis_*                     merged stream towards the switch core
//   m_axis_tready                switch ready
// -----------------------------------------------------------------------------
module nf10_upb_input_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 256
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  input  logic [NUM_PORTS*3-1:0]      s_axis_tuser_in_vport,
  input  logic [NUM_PORTS*14-1:0]     s_axis_tuser_packet_length,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [DATA_W/8-1:0]         m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [2:0]                  m_axis_tuser_in_port,
  output logic [2:0]                  m_axis_tuser_in_vport,
  output logic [7:0]                  m_axis_tuser_out_port,
  output logic [7:0]                  m_axis_tuser_out_vport,
  output logic [13:0]                 m_axis_tuser_packet_length,
  input  logic                        m_axis_tready
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [9:0]  beat_cnt_q, beat_cnt_d;

  // Per-port views of the flattened input buses.
  logic [DATA_W-1:0] port_tdata  [NUM_PORTS];
  logic [KEEP_W-1:0] port_tkeep  [NUM_PORTS];
  logic [2:0]        port_vport  [NUM_PORTS];
  logic [13:0]       port_len    [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign port_tdata[gi] = s_axis_tdata[gi*DATA_W +: DATA_W];
    assign port_tkeep[gi] = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
    assign port_vport[gi] = s_axis_tuser_in_vport[gi*3 +: 3];
    assign port_len[gi]   = s_axis_tuser_packet_length[gi*14 +: 14];
  end

  // Round-robin search: first requester after 'base', wrapping modulo
  // NUM_PORTS. Scanning from the far end lets the nearest hit win. If nobody
  // requests, 'base' comes back unchanged and the caller ignores it.
  function automatic logic [2:0] rr_pick(input logic [2:0]           base,
                                         input logic [NUM_PORTS-1:0] req);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = base;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = 3'((int'(base) + k) % NUM_PORTS);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  logic       send;
  logic       beat_acc;
  logic       last_acc;
  logic       any_req;
  logic [2:0] search_base;
  logic [2:0] search_pick;

  assign send = (state_q == SEND);

  // Zero-latency datapath: the granted port is muxed straight through.
  // Outside SEND everything is forced to zero, which also makes an
  // asynchronous reset blank the outputs immediately.
  assign m_axis_tvalid              = send & s_axis_tvalid[grant_q];
  assign m_axis_tlast               = send & s_axis_tlast[grant_q];
  assign m_axis_tdata               = send ? port_tdata[grant_q] : '0;
  assign m_axis_tkeep               = send ? port_tkeep[grant_q] : '0;
  assign m_axis_tuser_in_port       = send ? grant_q : 3'd0;
  assign m_axis_tuser_in_vport      = send ? port_vport[grant_q] : 3'd0;
  assign m_axis_tuser_packet_length = send ? port_len[grant_q] : 14'd0;
  assign m_axis_tuser_out_port      = 8'd0;
  assign m_axis_tuser_out_vport     = 8'd0;

  always_comb begin
    s_axis_tready = '0;
    if (send && m_axis_tready) s_axis_tready[grant_q] = 1'b1;
  end

  assign beat_acc = m_axis_tvalid & m_axis_tready;
  assign last_acc = beat_acc & m_axis_tlast;
  assign any_req  = |s_axis_tvalid;

  // On the closing beat the packet's own port becomes the new rotation
  // origin, so the next winner is computed in the same cycle (no bubble).
  assign search_base = last_acc ? grant_q : last_grant_q;
  assign search_pick = rr_pick(search_base, s_axis_tvalid);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = search_pick;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_acc) begin
          last_grant_d = grant_q;
          beat_cnt_d   = '0;
          if (any_req) grant_d = search_pick;
          else         state_d = IDLE;
        end else if (beat_acc && beat_cnt_q != 10'h3FF) begin
          beat_cnt_d = beat_cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 3'd0;
      last_grant_q <= 3'(NUM_PORTS - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_nf10_upb_input_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nf10_upb_input_arbiter
//
// Per-port source queues drive the DUT; an expected-beat queue is built from
// a packet-level round-robin model (rotate over ports that still hold
// packets, starting after port NUM_PORTS-1). A monitor process pops and
// compares every accepted output beat, checks hold-while-stalled and that
// no non-granted port is offered tready.
// -----------------------------------------------------------------------------
module tb_nf10_upb_input_arbiter;

  localparam int NP = 5;
  localparam int DW = 256;
  localparam int KW = DW / 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NP*DW-1:0]  s_tdata = '0;
  logic [NP*KW-1:0]  s_tkeep = '0;
  logic [NP-1:0]     s_tvalid = '0;
  logic [NP-1:0]     s_tlast = '0;
  logic [NP*3-1:0]   s_vport = '0;
  logic [NP*14-1:0]  s_len = '0;
  logic [NP-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic [2:0]        m_in_port;
  logic [2:0]        m_in_vport;
  logic [7:0]        m_out_port;
  logic [7:0]        m_out_vport;
  logic [13:0]       m_len;
  logic              m_tready = 1'b0;

  always #5 clk = ~clk;

  nf10_upb_input_arbiter #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .s_axis_tdata               (s_tdata),
    .s_axis_tkeep               (s_tkeep),
    .s_axis_tvalid              (s_tvalid),
    .s_axis_tlast               (s_tlast),
    .s_axis_tuser_in_vport      (s_vport),
    .s_axis_tuser_packet_length (s_len),
    .s_axis_tready              (s_tready),
    .m_axis_tdata               (m_tdata),
    .m_axis_tkeep               (m_tkeep),
    .m_axis_tvalid              (m_tvalid),
    .m_axis_tlast               (m_tlast),
    .m_axis_tuser_in_port       (m_in_port),
    .m_axis_tuser_in_vport      (m_in_vport),
    .m_axis_tuser_out_port      (m_out_port),
    .m_axis_tuser_out_vport     (m_out_vport),
    .m_axis_tuser_packet_length (m_len),
    .m_axis_tready              (m_tready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [2:0]    vport;
    logic [13:0]   len;
    logic [2:0]    port;
  } beat_t;

  beat_t src_q [NP][$];
  beat_t exp_q [$];
  int    gap_cnt [NP];
  int    checks = 0;
  int    failures = 0;
  int    popped = 0;

  function automatic void chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic add_packet(input int p, input int nbeats);
    beat_t      x;
    logic [2:0] vp;
    vp = 3'($urandom_range(0, 7));
    for (int b = 0; b < nbeats; b++) begin
      for (int w = 0; w < DW/32; w++) x.data[w*32 +: 32] = $urandom;
      x.keep  = (b == nbeats-1) ? (KW'($urandom) | KW'(1)) : '1;
      x.last  = (b == nbeats-1);
      x.vport = vp;
      x.len   = 14'(nbeats * 32);
      x.port  = 3'(p);
      src_q[p].push_back(x);
    end
  endtask

  // Packet-level round robin over ports still holding packets.
  task automatic build_expected();
    int    left [NP];
    int    rd [NP];
    int    last_p;
    int    p;
    beat_t b;
    last_p = NP - 1;
    for (int i = 0; i < NP; i++) begin
      left[i] = 0;
      rd[i]   = 0;
      foreach (src_q[i][j]) if (src_q[i][j].last) left[i]++;
    end
    forever begin
      p = -1;
      for (int k = 1; k <= NP; k++)
        if (p < 0 && left[(last_p + k) % NP] > 0) p = (last_p + k) % NP;
      if (p < 0) break;
      do begin
        b = src_q[p][rd[p]];
        rd[p]++;
        exp_q.push_back(b);
      end while (!b.last);
      left[p]--;
      last_p = p;
    end
  endtask

  task automatic drive_ports();
    for (int p = 0; p < NP; p++) begin
      if (gap_cnt[p] == 0 && src_q[p].size() > 0) begin
        s_tvalid[p]          = 1'b1;
        s_tdata[p*DW +: DW]  = src_q[p][0].data;
        s_tkeep[p*KW +: KW]  = src_q[p][0].keep;
        s_tlast[p]           = src_q[p][0].last;
        s_vport[p*3 +: 3]    = src_q[p][0].vport;
        s_len[p*14 +: 14]    = src_q[p][0].len;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk(m_tvalid === 1'b0 && m_tlast === 1'b0, {tag, "_valid_last"},
        $sformatf("got valid=%b last=%b want 0/0", m_tvalid, m_tlast));
    chk(m_tdata === '0 && m_tkeep === '0, {tag, "_data_keep"},
        $sformatf("got data=%h keep=%h want 0", m_tdata, m_tkeep));
    chk(m_in_port === 3'd0 && m_in_vport === 3'd0 && m_out_port === 8'd0 &&
        m_out_vport === 8'd0 && m_len === 14'd0, {tag, "_tuser"},
        $sformatf("got in_port=%0d vport=%0d out=%0d/%0d len=%0d want 0",
                  m_in_port, m_in_vport, m_out_port, m_out_vport, m_len));
    chk(s_tready === '0, {tag, "_s_tready"}, $sformatf("got %b want 0", s_tready));
  endtask

  task automatic do_reset();
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    resetn   = 1'b0;
    #1;
    check_idle("reset");
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      gap_cnt[p] = 0;
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready low on cycles 4..9
  // gmode: 0 no source gaps, 1 random mid-packet gaps, 2 one 3-cycle gap
  task automatic run_phase(input int rmode, input int gmode,
                           input int exp_cycles, input int abort_n);
    int    c;
    bit    fire [NP];
    bit    gap_done;
    beat_t b;
    c        = 0;
    gap_done = 1'b0;
    popped   = 0;
    @(posedge clk);
    #1;
    drive_ports();
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      c++;
      for (int p = 0; p < NP; p++) fire[p] = s_tvalid[p] & s_tready[p];
      if (abort_n < 0 && exp_q.size() == 0) break;
      if (c >= 3000) begin
        chk(1'b0, "timeout", $sformatf("got %0d beats pending after %0d cycles want 0",
                                       exp_q.size(), c));
        return;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (fire[p]) begin
          b = src_q[p].pop_front();
          if (!b.last && gmode == 1 && $urandom_range(0, 3) == 0)
            gap_cnt[p] = $urandom_range(1, 3);
          if (!b.last && gmode == 2 && !gap_done) begin
            gap_cnt[p] = 3;
            gap_done   = 1'b1;
          end
        end else if (gap_cnt[p] > 0) begin
          gap_cnt[p]--;
        end
      end
      drive_ports();
      case (rmode)
        1:       m_tready = ($urandom_range(0, 3) != 0);
        2:       m_tready = !((c + 1) >= 4 && (c + 1) <= 9);
        default: m_tready = 1'b1;
      endcase
      if (abort_n >= 0 && popped >= abort_n) return;
    end
    if (exp_cycles >= 0)
      chk(c == exp_cycles, "phase_cycles",
          $sformatf("got %0d cycles want %0d", c, exp_cycles));
  endtask

  // ---------------- monitor / scoreboard ----------------
  beat_t         mon_e;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] pv_data;
  logic [KW-1:0] pv_keep;
  logic          pv_last;
  logic [2:0]    pv_port;
  logic [2:0]    pv_vport;
  logic [13:0]   pv_len;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk(m_tvalid && m_tdata == pv_data && m_tkeep == pv_keep && m_tlast == pv_last &&
            m_in_port == pv_port && m_in_vport == pv_vport && m_len == pv_len,
            "stall_hold", $sformatf("got valid=%b port=%0d last=%b data=%h want held port=%0d last=%b data=%h",
                                    m_tvalid, m_in_port, m_tlast, m_tdata, pv_port, pv_last, pv_data));
      if (exp_q.size() > 0)
        chk((s_tready & ~(NP'(1) << exp_q[0].port)) == '0, "tready_nongrant",
            $sformatf("got s_tready=%b want only port %0d", s_tready, exp_q[0].port));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", $sformatf("got beat from port %0d want none", m_in_port));
        end else begin
          mon_e = exp_q.pop_front();
          popped++;
          chk(m_in_port == mon_e.port, "in_port",
              $sformatf("got %0d want %0d", m_in_port, mon_e.port));
          chk(m_tdata == mon_e.data && m_tkeep == mon_e.keep && m_tlast == mon_e.last,
              "beat", $sformatf("got last=%b keep=%h data=%h want last=%b keep=%h data=%h",
                                m_tlast, m_tkeep, m_tdata, mon_e.last, mon_e.keep, mon_e.data));
          chk(m_in_vport == mon_e.vport && m_len == mon_e.len && m_out_port == 8'd0 &&
              m_out_vport == 8'd0, "tuser",
              $sformatf("got vport=%0d len=%0d out=%0d/%0d want vport=%0d len=%0d out=0/0",
                        m_in_vport, m_len, m_out_port, m_out_vport, mon_e.vport, mon_e.len));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      pv_data  = m_tdata;
      pv_keep  = m_tkeep;
      pv_last  = m_tlast;
      pv_port  = m_in_port;
      pv_vport = m_in_vport;
      pv_len   = m_len;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    do_reset();

    // Two-beat packet on port 0: arbitration cycle then two beats.
    add_packet(0, 2);
    build_expected();
    run_phase(0, 0, 3, -1);
    $display("phase single_port0: checks=%0d failures=%0d", checks, failures);

    // Ports 0,1,2 with continuous single-beat packets: no bubbles.
    do_reset();
    for (int r = 0; r < 4; r++) for (int p = 0; p < 3; p++) add_packet(p, 1);
    build_expected();
    run_phase(0, 0, 13, -1);
    $display("phase rr_012: checks=%0d failures=%0d", checks, failures);

    // Seven-beat packet on port 1 with port 3 waiting.
    do_reset();
    add_packet(1, 7);
    add_packet(3, 2);
    build_expected();
    run_phase(0, 0, 10, -1);
    $display("phase hold_port1: checks=%0d failures=%0d", checks, failures);

    // Same traffic with six cycles of downstream backpressure mid-packet.
    do_reset();
    add_packet(1, 7);
    add_packet(3, 2);
    build_expected();
    run_phase(2, 0, 16, -1);
    $display("phase stall6: checks=%0d failures=%0d", checks, failures);

    // Granted port pauses 3 cycles mid-packet while port 2 waits.
    do_reset();
    add_packet(0, 3);
    add_packet(2, 2);
    build_expected();
    run_phase(0, 2, 9, -1);
    $display("phase src_gap: checks=%0d failures=%0d", checks, failures);

    // Single requester re-granted back-to-back.
    do_reset();
    for (int r = 0; r < 3; r++) add_packet(3, 2);
    build_expected();
    run_phase(0, 0, 7, -1);
    $display("phase single_rr: checks=%0d failures=%0d", checks, failures);

    // Reset during beat 3 of 5, then ports 0 and 4 compete.
    do_reset();
    add_packet(0, 5);
    build_expected();
    run_phase(0, 0, -1, 2);
    #2;
    chk(m_tvalid === 1'b1 && exp_q.size() > 0 && m_tdata == exp_q[0].data, "pre_reset_beat3",
        $sformatf("got valid=%b data=%h want beat 3 visible", m_tvalid, m_tdata));
    do_reset();
    add_packet(0, 2);
    add_packet(4, 2);
    build_expected();
    run_phase(0, 0, 5, -1);
    $display("phase mid_reset: checks=%0d failures=%0d", checks, failures);

    // Randomised traffic, backpressure and source gaps.
    for (int ph = 0; ph < 25; ph++) begin
      do_reset();
      n = 0;
      for (int p = 0; p < NP; p++) begin
        repeat ($urandom_range(0, 3)) begin
          add_packet(p, $urandom_range(1, 6));
          n++;
        end
      end
      if (n == 0) add_packet($urandom_range(0, NP-1), 3);
      build_expected();
      run_phase(1, 1, -1, -1);
    end
    $display("phase random: checks=%0d failures=%0d", checks, failures);

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
